if_stage_ctrl: RTL and testbench

Fetch-stage controller that consumes the load-use stall signals driven by the hazard unit and the branch redirect from EX. It owns the PC register, the instruction-memory request handshake, and the IF/ID pipeline register. It holds, advances, buffers or flushes each of these so that a stalled or squashed fetch never loses or duplicates an instruction. It sits between instruction memory and the decode stage.

---
 rtl/if_stage_ctrl_if.sv | 11 +
 rtl/if_stage_ctrl.sv | 108 ++++++++++
 tb/tb_if_stage_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_ctrl_if.sv
// Instruction-memory fetch channel between the fetch controller and instruction memory.
// Handshake: a word transfers on any cycle where req && ready; addr must stay stable while req && !ready.
interface if_stage_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_stage_ctrl.sv
// Fetch-stage controller: owns the PC, the imem request and the IF/ID register, with a
// one-entry skid buffer so a word returned during a stall is parked rather than refetched.
module if_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pc_write,
  input  logic                  ifid_write,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_target,
  if_stage_ctrl_if.master       imem,
  output logic [31:0]           ifid_pc,
  output logic [31:0]           ifid_instr,
  output logic                  ifid_valid,
  output logic                  fetch_stall,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        req_q;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;

  logic stall;
  logic fetch_done;

  // The hazard unit drives both enables together; either one low is a stall.
  assign stall      = !pc_write || !ifid_write;
  assign fetch_done = req_q && imem.ready;

  assign imem.req    = req_q;
  assign imem.addr   = pc;
  assign fetch_stall = (state == RUN) && !imem.ready;
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      req_q      <= 1'b0;
      ifid_pc    <= 32'h0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      skid_pc    <= 32'h0;
      skid_instr <= 32'h0;
    end else if (branch_taken) begin
      // Redirect squashes IF/ID, the skid and any word returning this cycle.
      state      <= RUN;
      pc         <= branch_target;
      req_q      <= 1'b1;
      ifid_pc    <= 32'h0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      skid_pc    <= 32'h0;
      skid_instr <= 32'h0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
          req_q <= 1'b1;
        end
        RUN: begin
          if (stall) begin
            if (fetch_done) begin
              // Park the returned word and move on so it is never fetched twice.
              skid_pc    <= pc;
              skid_instr <= imem.rdata;
              pc         <= pc + 32'd4;
              req_q      <= 1'b0;
              state      <= HELD;
            end
          end else if (fetch_done) begin
            ifid_pc    <= pc;
            ifid_instr <= imem.rdata;
            ifid_valid <= 1'b1;
            pc         <= pc + 32'd4;
          end else begin
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
          end
        end
        HELD: begin
          if (!stall) begin
            ifid_pc    <= skid_pc;
            ifid_instr <= skid_instr;
            ifid_valid <= 1'b1;
            req_q      <= 1'b1;
            state      <= RUN;
          end
        end
        default: begin
          state <= BOOT;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl: reset/boot, streaming, stall skid, memory wait,
// branch flush, mid-run reset and PC wrap on a second instance.
module tb_if_stage_ctrl;

  logic        clk;
  logic        rst_n;
  logic        pc_write;
  logic        ifid_write;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic [31:0] ifid_pc, ifid_instr;
  logic        ifid_valid, fetch_stall;
  logic [1:0]  state_dbg;

  logic [31:0] w_ifid_pc, w_ifid_instr;
  logic        w_ifid_valid, w_fetch_stall;
  logic [1:0]  w_state_dbg;

  int tests_run;
  int tests_failed;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0]  S_BOOT = 2'd0;
  localparam logic [1:0]  S_RUN  = 2'd1;
  localparam logic [1:0]  S_HELD = 2'd2;

  if_stage_ctrl_if mif ();
  if_stage_ctrl_if wif ();

  if_stage_ctrl u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (mif.master),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid),
    .fetch_stall   (fetch_stall),
    .state_dbg     (state_dbg)
  );

  if_stage_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (wif.master),
    .ifid_pc       (w_ifid_pc),
    .ifid_instr    (w_ifid_instr),
    .ifid_valid    (w_ifid_valid),
    .fetch_stall   (w_fetch_stall),
    .state_dbg     (w_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    mif.ready     = 1'b0;
    mif.rdata     = 32'h0;
    wif.ready     = 1'b0;
    wif.rdata     = 32'h0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    mif.ready     = 1'b0;
    mif.rdata     = 32'h0;
    wif.ready     = 1'b0;
    wif.rdata     = 32'h0;
    repeat (3) tick();
    tests_run++; if (mif.req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got=%h exp=0", mif.req); end
    tests_run++; if (mif.addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got=%h exp=0", mif.addr); end
    tests_run++; if (ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%h exp=0", ifid_valid); end
    tests_run++; if (ifid_instr !== NOP) begin tests_failed++; $display("FAIL reset_instr got=%h exp=%h", ifid_instr, NOP); end
    tests_run++; if (ifid_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_ifid_pc got=%h exp=0", ifid_pc); end
    tests_run++; if (fetch_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_fetch_stall got=%h exp=0", fetch_stall); end
    tests_run++; if (state_dbg !== S_BOOT) begin tests_failed++; $display("FAIL reset_state got=%h exp=%h", state_dbg, S_BOOT); end
    rst_n = 1'b1;
    tick();
    tests_run++; if (mif.req !== 1'b1) begin tests_failed++; $display("FAIL boot_req got=%h exp=1", mif.req); end
    tests_run++; if (mif.addr !== 32'h0) begin tests_failed++; $display("FAIL boot_addr got=%h exp=0", mif.addr); end
    tests_run++; if (state_dbg !== S_RUN) begin tests_failed++; $display("FAIL boot_state got=%h exp=%h", state_dbg, S_RUN); end
    tests_run++; if (ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL boot_valid got=%h exp=0", ifid_valid); end
  endtask

  task automatic test_streaming();
    logic [31:0] a;
    do_reset();
    mif.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 4);
      mif.rdata = word_at(a);
      tick();
      tests_run++; if (ifid_pc !== a) begin tests_failed++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, ifid_pc, a); end
      tests_run++; if (ifid_instr !== word_at(a)) begin tests_failed++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, ifid_instr, word_at(a)); end
      tests_run++; if (ifid_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_valid[%0d] got=%h exp=1", i, ifid_valid); end
      tests_run++; if (mif.addr !== a + 32'd4) begin tests_failed++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, mif.addr, a + 32'd4); end
    end
    mif.ready = 1'b0;
  endtask

  task automatic test_stall_skid();
    do_reset();
    mif.ready = 1'b1;
    mif.rdata = word_at(32'h0);
    tick();
    mif.rdata = word_at(32'h4);
    tick();
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    mif.rdata  = word_at(32'h8);
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++; if (ifid_pc !== 32'h4) begin tests_failed++; $display("FAIL stall_ifid_pc[%0d] got=%h exp=4", i, ifid_pc); end
      tests_run++; if (ifid_instr !== word_at(32'h4)) begin tests_failed++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, ifid_instr, word_at(32'h4)); end
      tests_run++; if (state_dbg !== S_HELD) begin tests_failed++; $display("FAIL stall_state[%0d] got=%h exp=%h", i, state_dbg, S_HELD); end
      tests_run++; if (mif.req !== 1'b0) begin tests_failed++; $display("FAIL stall_req[%0d] got=%h exp=0", i, mif.req); end
      tests_run++; if (mif.addr !== 32'hC) begin tests_failed++; $display("FAIL stall_addr[%0d] got=%h exp=c", i, mif.addr); end
    end
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    mif.ready  = 1'b0;
    tick();
    tests_run++; if (ifid_pc !== 32'h8) begin tests_failed++; $display("FAIL drain_pc got=%h exp=8", ifid_pc); end
    tests_run++; if (ifid_instr !== word_at(32'h8)) begin tests_failed++; $display("FAIL drain_instr got=%h exp=%h", ifid_instr, word_at(32'h8)); end
    tests_run++; if (ifid_valid !== 1'b1) begin tests_failed++; $display("FAIL drain_valid got=%h exp=1", ifid_valid); end
    tests_run++; if (mif.req !== 1'b1) begin tests_failed++; $display("FAIL drain_req got=%h exp=1", mif.req); end
    tests_run++; if (mif.addr !== 32'hC) begin tests_failed++; $display("FAIL drain_addr got=%h exp=c", mif.addr); end
    mif.ready = 1'b1;
    mif.rdata = word_at(32'hC);
    tick();
    tests_run++; if (ifid_pc !== 32'hC) begin tests_failed++; $display("FAIL after_drain_pc got=%h exp=c", ifid_pc); end
    mif.ready = 1'b0;
  endtask

  task automatic test_mem_wait();
    do_reset();
    mif.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mif.rdata = word_at(32'(i * 4));
      tick();
    end
    mif.ready = 1'b0;
    mif.rdata = 32'hDEAD_BEEF;
    #1;
    tests_run++; if (fetch_stall !== 1'b1) begin tests_failed++; $display("FAIL wait_fetch_stall_pre got=%h exp=1", fetch_stall); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (fetch_stall !== 1'b1) begin tests_failed++; $display("FAIL wait_fetch_stall[%0d] got=%h exp=1", i, fetch_stall); end
      tests_run++; if (ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL wait_valid[%0d] got=%h exp=0", i, ifid_valid); end
      tests_run++; if (ifid_instr !== NOP) begin tests_failed++; $display("FAIL wait_instr[%0d] got=%h exp=%h", i, ifid_instr, NOP); end
      tests_run++; if (ifid_pc !== 32'hC) begin tests_failed++; $display("FAIL wait_ifid_pc[%0d] got=%h exp=c", i, ifid_pc); end
      tests_run++; if (mif.addr !== 32'h10) begin tests_failed++; $display("FAIL wait_addr[%0d] got=%h exp=10", i, mif.addr); end
    end
    mif.ready = 1'b1;
    mif.rdata = word_at(32'h10);
    #1;
    tests_run++; if (fetch_stall !== 1'b0) begin tests_failed++; $display("FAIL ready_fetch_stall got=%h exp=0", fetch_stall); end
    tick();
    tests_run++; if (ifid_pc !== 32'h10) begin tests_failed++; $display("FAIL ready_pc got=%h exp=10", ifid_pc); end
    tests_run++; if (ifid_instr !== word_at(32'h10)) begin tests_failed++; $display("FAIL ready_instr got=%h exp=%h", ifid_instr, word_at(32'h10)); end
    tests_run++; if (ifid_valid !== 1'b1) begin tests_failed++; $display("FAIL ready_valid got=%h exp=1", ifid_valid); end
    mif.ready = 1'b0;
  endtask

  task automatic test_branch_in_stall();
    do_reset();
    mif.ready = 1'b1;
    mif.rdata = word_at(32'h0);
    tick();
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    mif.rdata  = word_at(32'h4);
    tick();
    tests_run++; if (state_dbg !== S_HELD) begin tests_failed++; $display("FAIL br_pre_state got=%h exp=%h", state_dbg, S_HELD); end
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    tests_run++; if (ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL br_valid got=%h exp=0", ifid_valid); end
    tests_run++; if (ifid_instr !== NOP) begin tests_failed++; $display("FAIL br_instr got=%h exp=%h", ifid_instr, NOP); end
    tests_run++; if (ifid_pc !== 32'h0) begin tests_failed++; $display("FAIL br_ifid_pc got=%h exp=0", ifid_pc); end
    tests_run++; if (mif.addr !== 32'h100) begin tests_failed++; $display("FAIL br_addr got=%h exp=100", mif.addr); end
    tests_run++; if (mif.req !== 1'b1) begin tests_failed++; $display("FAIL br_req got=%h exp=1", mif.req); end
    tests_run++; if (state_dbg !== S_RUN) begin tests_failed++; $display("FAIL br_state got=%h exp=%h", state_dbg, S_RUN); end
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    mif.rdata  = word_at(32'h100);
    tick();
    tests_run++; if (ifid_pc !== 32'h100) begin tests_failed++; $display("FAIL br_next_pc got=%h exp=100", ifid_pc); end
    tests_run++; if (ifid_instr !== word_at(32'h100)) begin tests_failed++; $display("FAIL br_next_instr got=%h exp=%h", ifid_instr, word_at(32'h100)); end
    // Redirect in RUN while memory returns a word: that word must be dropped.
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    mif.rdata     = word_at(32'h104);
    tick();
    branch_taken = 1'b0;
    tests_run++; if (ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL br_run_valid got=%h exp=0", ifid_valid); end
    tests_run++; if (mif.addr !== 32'h40) begin tests_failed++; $display("FAIL br_run_addr got=%h exp=40", mif.addr); end
    mif.ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mif.ready = 1'b1;
    mif.rdata = word_at(32'h0);
    tick();
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    mif.rdata  = word_at(32'h4);
    tick();
    rst_n = 1'b0;
    tick();
    tests_run++; if (state_dbg !== S_BOOT) begin tests_failed++; $display("FAIL mid_rst_state got=%h exp=%h", state_dbg, S_BOOT); end
    tests_run++; if (mif.req !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_req got=%h exp=0", mif.req); end
    tests_run++; if (mif.addr !== 32'h0) begin tests_failed++; $display("FAIL mid_rst_addr got=%h exp=0", mif.addr); end
    tests_run++; if (ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_valid got=%h exp=0", ifid_valid); end
    tests_run++; if (ifid_instr !== NOP) begin tests_failed++; $display("FAIL mid_rst_instr got=%h exp=%h", ifid_instr, NOP); end
    rst_n      = 1'b1;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    mif.ready  = 1'b0;
    tick();
    tick();
    tests_run++; if (ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_noskid got=%h exp=0", ifid_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    tests_run++; if (wif.addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", wif.addr); end
    wif.ready = 1'b1;
    wif.rdata = word_at(32'hFFFF_FFFC);
    tick();
    tests_run++; if (wif.addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_addr1 got=%h exp=0", wif.addr); end
    tests_run++; if (w_ifid_pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_ifid_pc0 got=%h exp=fffffffc", w_ifid_pc); end
    wif.rdata = word_at(32'h0);
    tick();
    tests_run++; if (w_ifid_pc !== 32'h0) begin tests_failed++; $display("FAIL wrap_ifid_pc1 got=%h exp=0", w_ifid_pc); end
    tests_run++; if (w_ifid_instr !== word_at(32'h0)) begin tests_failed++; $display("FAIL wrap_instr1 got=%h exp=%h", w_ifid_instr, word_at(32'h0)); end
    tests_run++; if (wif.addr !== 32'h4) begin tests_failed++; $display("FAIL wrap_addr2 got=%h exp=4", wif.addr); end
    wif.ready = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_streaming();
    test_stall_skid();
    test_mem_wait();
    test_branch_in_stall();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
